// File: rtl/flood_win_checker.sv
// Move counter and post-fill board scanner for the flood-fill game: flags WIN/LOSE.
// Define MOVE_BCD_EN to add the MOVES_BCD output (3-digit BCD copy of MOVES).
module flood_win_checker #(
  parameter int MAX_SIZE = 26,
  parameter int COORD_W  = 5,
  parameter int COLOR_W  = 3,
  parameter int MOVE_W   = 7
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START_NEW_GAME,
  input  logic [COORD_W-1:0] SIZE,
  input  logic [MOVE_W-1:0]  MOVE_LIMIT,
  input  logic               CHANGING_COLOR,
  output logic [COORD_W-1:0] RD_ROW,
  output logic [COORD_W-1:0] RD_COL,
  input  logic [COLOR_W-1:0] RD_DATA,
  output logic               SCAN_BUSY,
  output logic [MOVE_W-1:0]  MOVES,
  output logic               WIN,
  output logic               LOSE,
  output logic               GAME_OVER
`ifdef MOVE_BCD_EN
  ,
  output logic [11:0]        MOVES_BCD
`endif
);

  typedef enum logic [1:0] {IDLE, REF, SCAN, FIN} state_t;

  localparam logic [COORD_W-1:0] MAX_S     = COORD_W'(MAX_SIZE);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic [MOVE_W-1:0]  MOVES_MAX = '1;

  state_t             state;
  logic               cc_q;
  logic               fall;
  logic               rise;
  logic               match_q;
  logic [COLOR_W-1:0] ref_color;
  logic [COORD_W-1:0] seff;
  logic [COORD_W-1:0] seff_in;
  logic [COORD_W-1:0] last;

  assign fall      = cc_q & ~CHANGING_COLOR;
  assign rise      = ~cc_q & CHANGING_COLOR;
  assign GAME_OVER = WIN | LOSE;
  assign seff_in   = (SIZE > MAX_S) ? MAX_S : ((SIZE == '0) ? ONE : SIZE);
  assign last      = seff - ONE;

`ifdef MOVE_BCD_EN
  // Only called below 999, so the hundreds digit never overflows.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = '0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = '0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge CLOCK) begin
    cc_q <= CHANGING_COLOR;
    if (RESET || START_NEW_GAME) begin
      if (RESET) cc_q <= 1'b0;
      state     <= IDLE;
      MOVES     <= '0;
      WIN       <= 1'b0;
      LOSE      <= 1'b0;
      SCAN_BUSY <= 1'b0;
      RD_ROW    <= '0;
      RD_COL    <= '0;
      match_q   <= 1'b0;
      ref_color <= '0;
      seff      <= ONE;
`ifdef MOVE_BCD_EN
      MOVES_BCD <= '0;
`endif
    end else if (fall && !GAME_OVER) begin
      if (MOVES != MOVES_MAX) MOVES <= MOVES + MOVE_W'(1);
`ifdef MOVE_BCD_EN
      if (MOVES != MOVES_MAX && MOVES_BCD != 12'h999) MOVES_BCD <= bcd_inc(MOVES_BCD);
`endif
      seff      <= seff_in;
      state     <= REF;
      SCAN_BUSY <= 1'b1;
      RD_ROW    <= '0;
      RD_COL    <= '0;
    end else if (rise && (state == REF || state == SCAN)) begin
      // A new fill started before the scan finished; the next fall re-evaluates.
      state     <= IDLE;
      SCAN_BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        REF: begin
          ref_color <= RD_DATA;
          if (seff == ONE) begin
            match_q <= 1'b1;
            state   <= FIN;
          end else begin
            RD_COL <= ONE;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // A mismatch drops SCAN_BUSY immediately; a full match drops it in FIN.
          if (RD_DATA != ref_color) begin
            match_q   <= 1'b0;
            SCAN_BUSY <= 1'b0;
            state     <= FIN;
          end else if (RD_ROW == last && RD_COL == last) begin
            match_q <= 1'b1;
            state   <= FIN;
          end else if (RD_COL == last) begin
            RD_COL <= '0;
            RD_ROW <= RD_ROW + ONE;
          end else begin
            RD_COL <= RD_COL + ONE;
          end
        end
        FIN: begin
          SCAN_BUSY <= 1'b0;
          state     <= IDLE;
          if (match_q) WIN <= 1'b1;
          else if (MOVE_LIMIT != '0 && MOVES >= MOVE_LIMIT) LOSE <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flood_win_checker.sv
// Randomized bench for flood_win_checker against a transaction-level model of one fill.
module tb_flood_win_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_new_game;
  logic       changing_color;
  logic [4:0] size;
  logic [6:0] move_limit;
  logic [4:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rd_data;
  logic       scan_busy;
  logic [6:0] moves;
  logic       win;
  logic       lose;
  logic       game_over;
`ifdef MOVE_BCD_EN
  logic [11:0] moves_bcd;
`endif

  logic [2:0] board [32][32];
  int checks = 0;
  int errors = 0;
  int m_moves, m_row, m_col;
  bit m_win, m_lose;

  always #5 clock = ~clock;
  assign rd_data = board[rd_row][rd_col];

  flood_win_checker #(.MAX_SIZE(26), .COORD_W(5), .COLOR_W(3), .MOVE_W(7)) dut (
    .CLOCK(clock),
    .RESET(reset),
    .START_NEW_GAME(start_new_game),
    .SIZE(size),
    .MOVE_LIMIT(move_limit),
    .CHANGING_COLOR(changing_color),
    .RD_ROW(rd_row),
    .RD_COL(rd_col),
    .RD_DATA(rd_data),
    .SCAN_BUSY(scan_busy),
    .MOVES(moves),
    .WIN(win),
    .LOSE(lose),
    .GAME_OVER(game_over)
`ifdef MOVE_BCD_EN
    ,
    .MOVES_BCD(moves_bcd)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int eff_size(input int s);
    return (s > 26) ? 26 : ((s == 0) ? 1 : s);
  endfunction

  task automatic model_clear();
    m_moves = 0; m_win = 0; m_lose = 0; m_row = 0; m_col = 0;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_moves"}, int'(moves), 0);
    chk({tag, "_win"}, int'(win), 0);
    chk({tag, "_lose"}, int'(lose), 0);
    chk({tag, "_busy"}, int'(scan_busy), 0);
    chk({tag, "_row"}, int'(rd_row), 0);
    chk({tag, "_col"}, int'(rd_col), 0);
  endtask

  // Area seff x seff filled with colour; cell diff_idx (row-major) altered if >= 0.
  task automatic fill_board(input int color, input int seff, input int diff_idx);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        board[r][c] = (r < seff && c < seff) ? 3'(color) : 3'($urandom_range(0, 7));
    if (diff_idx >= 0)
      board[diff_idx / seff][diff_idx % seff] = 3'((color + 1 + $urandom_range(0, 6)) % 8);
  endtask

  task automatic new_game();
    @(negedge clock);
    start_new_game = 1'b1;
    @(negedge clock);
    start_new_game = 1'b0;
    model_clear();
    check_idle_state("newgame");
  endtask

  // One fill (CHANGING_COLOR 1 -> 0), then check against the model.
  task automatic do_fill(input string tag);
    int seff, total, n, idx, exp_busy, busy_cnt;
    bit match;
    seff  = eff_size(int'(size));
    total = seff * seff;
    n     = total;
    for (int i = 0; i < total; i++)
      if (board[i / seff][i % seff] != board[0][0]) begin
        n = i;
        break;
      end
    match = (n == total);
    if (!(m_win || m_lose)) begin
      if (m_moves < 127) m_moves++;
      exp_busy = match ? total + 1 : n + 1;
      idx      = match ? total - 1 : n;
      m_row    = idx / seff;
      m_col    = idx % seff;
      if (match) m_win = 1;
      else if (move_limit != 0 && m_moves >= int'(move_limit)) m_lose = 1;
    end else begin
      exp_busy = 0;
    end

    @(negedge clock);
    changing_color = 1'b1;
    @(negedge clock);
    changing_color = 1'b0;
    @(negedge clock);
    busy_cnt = 0;
    for (int t = 0; t < 2000 && scan_busy; t++) begin
      busy_cnt++;
      @(negedge clock);
    end
    chk({tag, "_timeout"}, int'(scan_busy), 0);
    @(negedge clock);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_moves"}, int'(moves), m_moves);
    chk({tag, "_win"}, int'(win), int'(m_win));
    chk({tag, "_lose"}, int'(lose), int'(m_lose));
    chk({tag, "_game_over"}, int'(game_over), int'(m_win | m_lose));
    chk({tag, "_row"}, int'(rd_row), m_row);
    chk({tag, "_col"}, int'(rd_col), m_col);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, nf;
    bit uni;
    reset = 1'b1; start_new_game = 1'b0; changing_color = 1'b0;
    size = 5'd2; move_limit = '0;
    fill_board(3, 2, -1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    check_idle_state("reset");

    // 2x2 uniform board: win after 5 busy cycles
    do_fill("size2_win");

    // 6x6 with last cell different: full 36-cell scan, no win
    new_game();
    size = 5'd6;
    fill_board(1, 6, 35);
    do_fill("size6_last");

    // (0,1) differs: early abort
    new_game();
    fill_board(1, 6, 1);
    do_fill("size6_first");

    // move limit reached: lose, then fills ignored
    new_game();
    move_limit = 7'd3;
    fill_board(2, 6, 7);
    for (int i = 0; i < 4; i++) do_fill("limit3");
    chk("limit3_frozen", int'(moves), 3);

    // start-new-game coinciding with a fall
    new_game();
    move_limit = '0;
    for (int i = 0; i < 4; i++) do_fill("pre_sng");
    @(negedge clock);
    changing_color = 1'b1;
    @(negedge clock);
    changing_color = 1'b0;
    start_new_game = 1'b1;
    @(negedge clock);
    start_new_game = 1'b0;
    model_clear();
    check_idle_state("sng_fall");
    @(negedge clock);
    chk("sng_fall_no_scan", int'(scan_busy), 0);

    // rising CHANGING_COLOR mid-scan aborts, next fall rescans
    fill_board(4, 6, -1);
    @(negedge clock);
    changing_color = 1'b1;
    @(negedge clock);
    changing_color = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    changing_color = 1'b1;
    @(negedge clock);
    chk("abort_busy", int'(scan_busy), 0);
    chk("abort_win", int'(win), 0);
    chk("abort_moves", int'(moves), 1);
    m_moves = 1;
    do_fill("after_abort");

    // reset during a scan
    new_game();
    fill_board(5, 6, 30);
    @(negedge clock);
    changing_color = 1'b1;
    @(negedge clock);
    changing_color = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    check_idle_state("reset_mid");

    // counter saturation
    size = 5'd2;
    fill_board(6, 2, 1);
    for (int i = 0; i < 130; i++) begin
      do_fill("sat");
`ifdef MOVE_BCD_EN
      if (i == 56) chk("bcd_57", int'(moves_bcd), 'h057);
`endif
    end
    chk("sat_moves", int'(moves), 127);
`ifdef MOVE_BCD_EN
    chk("bcd_sat", int'(moves_bcd), 'h127);
`endif

    // randomized games
    for (int g = 0; g < 10; g++) begin
      new_game();
      size = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 8));
      move_limit = 7'($urandom_range(0, 5));
      s  = eff_size(int'(size));
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        uni = ($urandom_range(0, 3) == 0);
        fill_board($urandom_range(0, 7), s, (uni || s == 1) ? -1 : $urandom_range(1, s * s - 1));
        do_fill("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
